rr_arbiter: RTL and testbench
=============================

RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N, default 16, SHALL set the number of requesters; power of two, 2..256.
REQ-002 Parameter MAX_HOLD, default 0, SHALL set the maximum consecutive cycles one grant is held; 0 means unlimited.
REQ-003 Derived constant IDX_W SHALL equal log2(N).
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req  in  N  per-requester request level; bit i is requester i.
REQ-007 gnt  out  N  one-hot grant vector; all-zero when no grant.
REQ-008 gnt_idx  out  IDX_W  binary index of the current grant.
REQ-009 gnt_valid  out  1  high while a grant is active.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE (no grant) and BUSY (grant active).
REQ-011 A priority pointer ptr (IDX_W bits) SHALL make index ptr the highest priority, then ptr+1, ..., wrapping mod N.
REQ-012 In IDLE with req non-zero, the block SHALL select the first set req bit at or after ptr (circular), register it into gnt_idx, set gnt_valid and enter BUSY; latency req-to-grant is exactly 1 cycle.
REQ-013 In IDLE with req zero, outputs SHALL hold gnt_valid=0 and gnt=0.
REQ-014 gnt SHALL equal the one-hot decode of gnt_idx when gnt_valid=1, and all-zero otherwise; gnt SHALL never have more than one bit set.
REQ-015 In BUSY, a release SHALL occur in a cycle where req[gnt_idx]=0, or, when MAX_HOLD>0, in the cycle where the hold counter shows gnt_valid has been high MAX_HOLD cycles for the current grant.
REQ-016 On release, ptr SHALL become gnt_idx+1 mod N, wrapping N-1 to 0.
REQ-017 On release, arbitration SHALL run in the same cycle using the updated priority order (start at gnt_idx+1); if any req bit is set, the new grant SHALL appear the next cycle with no idle gap and the state SHALL remain BUSY.
REQ-018 If no req bit is set on release, the block SHALL drive gnt_valid=0 the next cycle and enter IDLE.
REQ-019 On timeout with the current requester still requesting, that requester SHALL have lowest priority; if it is the sole requester, it SHALL be re-granted back-to-back with the hold counter restarted.
REQ-020 Requests arriving or dropping on non-granted indices during BUSY SHALL NOT alter the current grant.
REQ-021 The hold counter SHALL be wide enough for MAX_HOLD, SHALL reset to 0 on every new grant, and SHALL be absent/ignored when MAX_HOLD=0.

Reset
REQ-022 While rst=1 at a clock edge: state=IDLE, ptr=0, gnt_idx=0, gnt_valid=0, gnt=0, hold counter=0.
REQ-023 rst asserted in BUSY SHALL drop gnt on the following edge regardless of req; arbitration resumes one cycle after rst deasserts.

Structure
REQ-024 Package rr_arbiter_pkg SHALL hold the state enum typedef and the circular first-set-bit search function.
REQ-025 The one-hot gnt SHALL be produced by one instance of the existing bin2pos sub-module with BIN_WIDTH=IDX_W, gated by gnt_valid.

Verification (N=16, MAX_HOLD=4 unless stated)
REQ-026 Reset, then req=16'h0001 held -> next cycle gnt=16'h0001, gnt_idx=0, gnt_valid=1; MAX_HOLD=0 -> held indefinitely.
REQ-027 From IDLE, ptr=0, req=16'h8001 in the same cycle -> grant idx 0 first; drop req[0] -> next cycle gnt=16'h8000, idx 15, no gap.
REQ-028 Wrap: release of idx 15 -> ptr=0; req=16'h0003 -> gnt_idx=0.
REQ-029 req=16'h0005 held constantly -> idx 0 for 4 cycles, idx 2 for 4 cycles, alternating; gnt_valid never drops.
REQ-030 req=16'h0010 held constantly -> idx 4 re-granted every 4 cycles, gnt_valid continuously 1.
REQ-031 rst pulse during BUSY on idx 7 -> gnt=0 next edge; then req=16'hFFFF -> gnt_idx=0; assert gnt one-hot-or-zero and gnt==1<<gnt_idx every cycle.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// The search helper works on a 256-bit window so one function covers every legal N.
package rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Index of the first set bit at or after start, wrapping within mask+1 entries.
  function automatic logic [7:0] first_set_from(
    input logic [255:0] vec,
    input logic [7:0]   start,
    input logic [7:0]   mask
  );
    logic [7:0] idx;
    logic [7:0] cand;
    logic       found;
    idx   = 8'd0;
    found = 1'b0;
    for (int k = 0; k < 256; k++) begin
      cand = (start + 8'(k)) & mask;
      if (!found && vec[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_bin2pos.sv
// Binary index to one-hot position decoder; purely combinational.
module bin2pos #(
  parameter int BIN_WIDTH = 4
) (
  input  logic [BIN_WIDTH-1:0]    bin,
  output logic [2**BIN_WIDTH-1:0] pos
);

  always_comb begin
    pos      = '0;
    pos[bin] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with optional hold limit: request-to-grant latency 1 cycle,
// back-to-back regrant on release, no backpressure beyond the request levels themselves.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter  int N        = 16,
  parameter  int MAX_HOLD = 0,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  localparam int                HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [7:0]        MASK      = 8'(N - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic [IDX_W-1:0]  after_cur;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              timeout;
  logic [N-1:0]      pos;

  assign after_cur = gnt_idx + IDX_W'(1);
  // hold_cnt counts completed cycles of the current grant, so LAST marks its final cycle
  assign timeout   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt_idx  <= idx_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = gnt_idx;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = BUSY;
          idx_nxt   = IDX_W'(first_set_from(256'(req), 8'(ptr), MASK));
          hold_nxt  = '0;
        end
      end
      BUSY: begin
        if (!req[gnt_idx] || timeout) begin
          // Re-arbitrate in the release cycle so the current holder ranks last.
          ptr_nxt = after_cur;
          if (|req) begin
            idx_nxt  = IDX_W'(first_set_from(256'(req), 8'(after_cur), MASK));
            hold_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (MAX_HOLD != 0) begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  bin2pos #(
    .BIN_WIDTH(IDX_W)
  ) u_bin2pos (
    .bin(gnt_idx),
    .pos(pos)
  );

  always_comb begin
    gnt_valid = (state == BUSY);
    gnt       = gnt_valid ? pos : '0;
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed scoreboard bench: two arbiters (hold limit 4 and unlimited) share one request stream.
module tb_rr_arbiter;

  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt, gnt0;
  logic [IW-1:0] gnt_idx, gnt_idx0;
  logic          gnt_valid, gnt_valid0;

  always #5 clk = ~clk;

  rr_arbiter #(.N(N), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
  );

  rr_arbiter #(.N(N), .MAX_HOLD(0)) dut_nohold (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt0), .gnt_idx(gnt_idx0), .gnt_valid(gnt_valid0)
  );

  typedef struct {
    logic          v;
    logic [IW-1:0] idx;
    logic          v0;
    logic [IW-1:0] idx0;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;

  function automatic logic [N-1:0] onehot(input logic v, input logic [IW-1:0] i);
    logic [N-1:0] one;
    one = 16'd1;
    return v ? (one << i) : '0;
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Inputs applied before a rising edge; expected outputs are those seen just after it.
  task automatic step(input logic r, input logic [N-1:0] rq,
                      input logic v, input logic [IW-1:0] i,
                      input logic v0, input logic [IW-1:0] i0);
    exp_t e;
    @(negedge clk);
    rst    = r;
    req    = rq;
    e.v    = v;
    e.idx  = i;
    e.v0   = v0;
    e.idx0 = i0;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("valid", 16'(gnt_valid), 16'(e.v));
        if (e.v) check("idx", 16'(gnt_idx), 16'(e.idx));
        check("gnt", gnt, onehot(e.v, e.idx));
        check("onehot", 16'($countones(gnt) <= 1), 16'd1);
        check("valid_nohold", 16'(gnt_valid0), 16'(e.v0));
        if (e.v0) check("idx_nohold", 16'(gnt_idx0), 16'(e.idx0));
        check("gnt_nohold", gnt0, onehot(e.v0, e.idx0));
      end
    end
  end

  initial begin : stimulus
    repeat (2) step(1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b0, 16'h0001, 1'b1, 4'd0, 1'b1, 4'd0);
    repeat (6) step(1'b0, 16'h0001, 1'b1, 4'd0, 1'b1, 4'd0);
    step(1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0);
    // Simultaneous requests from IDLE, then hand-over with no gap and wrap of the pointer.
    step(1'b0, 16'h8001, 1'b1, 4'd0, 1'b1, 4'd0);
    step(1'b0, 16'h8000, 1'b1, 4'd15, 1'b1, 4'd15);
    step(1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b0, 16'h0003, 1'b1, 4'd0, 1'b1, 4'd0);
    // Two persistent requesters alternate every four cycles under the hold limit.
    repeat (3) step(1'b0, 16'h0005, 1'b1, 4'd0, 1'b1, 4'd0);
    repeat (4) step(1'b0, 16'h0005, 1'b1, 4'd2, 1'b1, 4'd0);
    repeat (4) step(1'b0, 16'h0005, 1'b1, 4'd0, 1'b1, 4'd0);
    step(1'b0, 16'h0005, 1'b1, 4'd2, 1'b1, 4'd0);
    // Sole requester is re-granted back-to-back across timeouts.
    repeat (9) step(1'b0, 16'h0010, 1'b1, 4'd4, 1'b1, 4'd4);
    repeat (2) step(1'b0, 16'h0080, 1'b1, 4'd7, 1'b1, 4'd7);
    step(1'b1, 16'h0080, 1'b0, 4'd0, 1'b0, 4'd0);
    repeat (4) step(1'b0, 16'hFFFF, 1'b1, 4'd0, 1'b1, 4'd0);
    repeat (4) step(1'b0, 16'hFFFF, 1'b1, 4'd1, 1'b1, 4'd0);
    step(1'b0, 16'hFFFF, 1'b1, 4'd2, 1'b1, 4'd0);
    step(1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
